// File: rtl/mem_ctrl_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : global_defs (package)
// Description : Shared memory-system types. Provides the request/response
//               field types used across the cache hierarchy plus the state
//               and owner encodings of the main-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package global_defs;

    localparam int ADDR_W         = 32;
    localparam int BLOCK_DATA_W   = 128;                 // 16-byte blocks
    localparam int BLOCK_OFFSET_W = $clog2(BLOCK_DATA_W / 8);
    localparam int BLOCK_ADDR_W   = ADDR_W - BLOCK_OFFSET_W;

    typedef logic [ADDR_W-1:0]       addr_t;
    typedef logic [BLOCK_ADDR_W-1:0] main_mem_block_addr_t;
    typedef logic [BLOCK_DATA_W-1:0] block_data_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } req_type_t;

    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        HALF  = 2'd1,
        WORD  = 2'd2,
        DWORD = 2'd3
    } req_width_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } mem_arb_state_t;

    typedef enum logic {
        OWNER_ICACHE = 1'b0,
        OWNER_DCACHE = 1'b1
    } mem_owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_starve_ctr
// Description : Saturating count of consecutive icache grants that were made
//               while the dcache was also requesting.
// Ports       : clk, rst_aH (async, active-high)
//               inc_i      - icache granted against a pending dcache request
//               clr_i      - dcache granted (clear wins over increment)
//               at_limit_o - count has reached STARVE_LIMIT
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_starve_ctr
    import global_defs::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_aH,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam int                 c_CTR_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CTR_W-1:0] c_LIMIT = c_CTR_W'(STARVE_LIMIT);

    logic [c_CTR_W-1:0] ctr_q;
    logic [c_CTR_W-1:0] ctr_d;

    assign at_limit_o = (ctr_q == c_LIMIT);

    always_comb begin
        ctr_d = ctr_q;
        if (clr_i) begin
            ctr_d = '0;
        end else if (inc_i && !at_limit_o) begin
            ctr_d = ctr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            ctr_q <= '0;
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_ctrl_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_arbiter
// Description : Single-outstanding arbiter between the icache and dcache
//               memory paths. The icache has static priority; a starvation
//               counter forces a dcache win after STARVE_LIMIT consecutive
//               contended icache grants. The granted request is registered
//               and presented to the memory controller; read responses are
//               routed back to the owning cache in the cycle they arrive.
// Ports       : clk, rst_aH (async, active-high)
//               icache_req_*  - icache read requests (in) / ready (out)
//               dcache_req_*  - dcache read/write requests (in) / ready (out)
//               icache_resp_*, dcache_resp_* - routed block responses (out)
//               mem_ctrl_req_*  - request stream to memory (out) / ready (in)
//               mem_ctrl_resp_* - block response from memory (in)
//               spurious_resp - sticky: response seen with no read pending
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl_arbiter
    import global_defs::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int VERBOSE      = 0
) (
    input  logic                 clk,
    input  logic                 rst_aH,

    input  logic                 icache_req_valid,
    input  main_mem_block_addr_t icache_req_block_addr,
    output logic                 icache_req_ready,

    input  logic                 dcache_req_valid,
    input  req_type_t            dcache_req_type,
    input  main_mem_block_addr_t dcache_req_block_addr,
    input  block_data_t          dcache_req_block_data,
    input  req_width_t           dcache_req_width,
    input  addr_t                dcache_req_addr,
    output logic                 dcache_req_ready,

    output logic                 icache_resp_valid,
    output block_data_t          icache_resp_block_data,
    output logic                 dcache_resp_valid,
    output block_data_t          dcache_resp_block_data,

    output logic                 mem_ctrl_req_valid,
    output req_type_t            mem_ctrl_req_type,
    output main_mem_block_addr_t mem_ctrl_req_block_addr,
    output block_data_t          mem_ctrl_req_block_data,
    output req_width_t           mem_ctrl_req_width,
    output addr_t                mem_ctrl_req_addr,
    input  logic                 mem_ctrl_req_ready,

    input  logic                 mem_ctrl_resp_valid,
    input  block_data_t          mem_ctrl_resp_block_data,

    output logic                 spurious_resp
);

    // Simulation-only tracing hook; intentionally produces no hardware.
    if (VERBOSE != 0) begin : g_verbose
    end

    mem_arb_state_t       state_q,      state_d;
    mem_owner_t           owner_q,      owner_d;
    req_type_t            req_type_q,   req_type_d;
    main_mem_block_addr_t req_baddr_q,  req_baddr_d;
    block_data_t          req_data_q,   req_data_d;
    req_width_t           req_width_q,  req_width_d;
    addr_t                req_addr_q,   req_addr_d;
    logic                 spurious_q,   spurious_d;

    logic w_grant_icache;
    logic w_grant_dcache;
    logic w_at_limit;

    mem_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk        (clk),
        .rst_aH     (rst_aH),
        .inc_i      (w_grant_icache && dcache_req_valid),
        .clr_i      (w_grant_dcache),
        .at_limit_o (w_at_limit)
    );

    // Grant depends only on state and request valids, never on
    // mem_ctrl_req_ready, so no combinational path reaches the upstream
    // readies from the memory side. Reset masks the grant so the readies
    // fall together with the asynchronous state reset.
    always_comb begin
        w_grant_icache = 1'b0;
        w_grant_dcache = 1'b0;
        if (state_q == IDLE && !rst_aH) begin
            w_grant_dcache = dcache_req_valid && (!icache_req_valid || w_at_limit);
            w_grant_icache = icache_req_valid && !w_grant_dcache;
        end
    end

    assign icache_req_ready = w_grant_icache;
    assign dcache_req_ready = w_grant_dcache;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        req_type_d  = req_type_q;
        req_baddr_d = req_baddr_q;
        req_data_d  = req_data_q;
        req_width_d = req_width_q;
        req_addr_d  = req_addr_q;
        case (state_q)
            IDLE: begin
                if (w_grant_icache) begin
                    owner_d     = OWNER_ICACHE;
                    req_type_d  = READ;
                    req_baddr_d = icache_req_block_addr;
                    req_data_d  = '0;
                    req_width_d = BYTE;
                    req_addr_d  = '0;
                    state_d     = ISSUE;
                end else if (w_grant_dcache) begin
                    owner_d     = OWNER_DCACHE;
                    req_type_d  = dcache_req_type;
                    req_baddr_d = dcache_req_block_addr;
                    req_data_d  = dcache_req_block_data;
                    req_width_d = dcache_req_width;
                    req_addr_d  = dcache_req_addr;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // Writes retire on acceptance; only reads wait for data.
                if (mem_ctrl_req_ready) begin
                    state_d = (req_type_q == READ) ? WAIT_RESP : IDLE;
                end
            end
            WAIT_RESP: begin
                if (mem_ctrl_resp_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A response is only legitimate while a read is outstanding.
    assign spurious_d = spurious_q || (mem_ctrl_resp_valid && state_q != WAIT_RESP);

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            state_q     <= IDLE;
            owner_q     <= OWNER_ICACHE;
            req_type_q  <= READ;
            req_baddr_q <= '0;
            req_data_q  <= '0;
            req_width_q <= BYTE;
            req_addr_q  <= '0;
            spurious_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            req_type_q  <= req_type_d;
            req_baddr_q <= req_baddr_d;
            req_data_q  <= req_data_d;
            req_width_q <= req_width_d;
            req_addr_q  <= req_addr_d;
            spurious_q  <= spurious_d;
        end
    end

    assign mem_ctrl_req_valid      = (state_q == ISSUE);
    assign mem_ctrl_req_type       = req_type_q;
    assign mem_ctrl_req_block_addr = req_baddr_q;
    assign mem_ctrl_req_block_data = req_data_q;
    assign mem_ctrl_req_width      = req_width_q;
    assign mem_ctrl_req_addr       = req_addr_q;

    assign icache_resp_valid = (state_q == WAIT_RESP) && mem_ctrl_resp_valid
                               && (owner_q == OWNER_ICACHE);
    assign dcache_resp_valid = (state_q == WAIT_RESP) && mem_ctrl_resp_valid
                               && (owner_q == OWNER_DCACHE);

    // Data is broadcast; each cache qualifies it with its own valid.
    assign icache_resp_block_data = mem_ctrl_resp_block_data;
    assign dcache_resp_block_data = mem_ctrl_resp_block_data;

    assign spurious_resp = spurious_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_ctrl_arbiter
// Description : Directed self-checking bench for mem_ctrl_arbiter with
//               STARVE_LIMIT = 2. Inputs change 1 time unit after each rising
//               edge; outputs are sampled 1 unit later, well before the next
//               edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl_arbiter;
    import global_defs::*;

    logic                 clk = 1'b0;
    logic                 rst_aH;
    logic                 icache_req_valid;
    main_mem_block_addr_t icache_req_block_addr;
    logic                 icache_req_ready;
    logic                 dcache_req_valid;
    req_type_t            dcache_req_type;
    main_mem_block_addr_t dcache_req_block_addr;
    block_data_t          dcache_req_block_data;
    req_width_t           dcache_req_width;
    addr_t                dcache_req_addr;
    logic                 dcache_req_ready;
    logic                 icache_resp_valid;
    block_data_t          icache_resp_block_data;
    logic                 dcache_resp_valid;
    block_data_t          dcache_resp_block_data;
    logic                 mem_ctrl_req_valid;
    req_type_t            mem_ctrl_req_type;
    main_mem_block_addr_t mem_ctrl_req_block_addr;
    block_data_t          mem_ctrl_req_block_data;
    req_width_t           mem_ctrl_req_width;
    addr_t                mem_ctrl_req_addr;
    logic                 mem_ctrl_req_ready;
    logic                 mem_ctrl_resp_valid;
    block_data_t          mem_ctrl_resp_block_data;
    logic                 spurious_resp;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_ctrl_arbiter #(
        .STARVE_LIMIT (2),
        .VERBOSE      (0)
    ) u_dut (
        .clk                      (clk),
        .rst_aH                   (rst_aH),
        .icache_req_valid         (icache_req_valid),
        .icache_req_block_addr    (icache_req_block_addr),
        .icache_req_ready         (icache_req_ready),
        .dcache_req_valid         (dcache_req_valid),
        .dcache_req_type          (dcache_req_type),
        .dcache_req_block_addr    (dcache_req_block_addr),
        .dcache_req_block_data    (dcache_req_block_data),
        .dcache_req_width         (dcache_req_width),
        .dcache_req_addr          (dcache_req_addr),
        .dcache_req_ready         (dcache_req_ready),
        .icache_resp_valid        (icache_resp_valid),
        .icache_resp_block_data   (icache_resp_block_data),
        .dcache_resp_valid        (dcache_resp_valid),
        .dcache_resp_block_data   (dcache_resp_block_data),
        .mem_ctrl_req_valid       (mem_ctrl_req_valid),
        .mem_ctrl_req_type        (mem_ctrl_req_type),
        .mem_ctrl_req_block_addr  (mem_ctrl_req_block_addr),
        .mem_ctrl_req_block_data  (mem_ctrl_req_block_data),
        .mem_ctrl_req_width       (mem_ctrl_req_width),
        .mem_ctrl_req_addr        (mem_ctrl_req_addr),
        .mem_ctrl_req_ready       (mem_ctrl_req_ready),
        .mem_ctrl_resp_valid      (mem_ctrl_resp_valid),
        .mem_ctrl_resp_block_data (mem_ctrl_resp_block_data),
        .spurious_resp            (spurious_resp)
    );

    task automatic check_value(input string tag, input logic [127:0] got,
                               input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam block_data_t c_DATA_AB = {16{8'hAB}};
    localparam block_data_t c_DATA_11 = {16{8'h11}};
    localparam block_data_t c_DATA_22 = {16{8'h22}};
    localparam block_data_t c_DATA_D  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    // Expected winners for the starvation scenario (1 = icache).
    logic [5:0] c_starve_icache_wins = 6'b011011;  // bit g = grant g

    initial begin
        rst_aH                   = 1'b1;
        icache_req_valid         = 1'b0;
        icache_req_block_addr    = '0;
        dcache_req_valid         = 1'b0;
        dcache_req_type          = READ;
        dcache_req_block_addr    = '0;
        dcache_req_block_data    = '0;
        dcache_req_width         = BYTE;
        dcache_req_addr          = '0;
        mem_ctrl_req_ready       = 1'b1;
        mem_ctrl_resp_valid      = 1'b0;
        mem_ctrl_resp_block_data = '0;

        // ---------------- reset state ----------------
        tick();
        tick();
        icache_req_valid = 1'b1;
        dcache_req_valid = 1'b1;
        #1;
        check_value("rst_icache_ready", icache_req_ready, 0);
        check_value("rst_dcache_ready", dcache_req_ready, 0);
        check_value("rst_mem_valid",    mem_ctrl_req_valid, 0);
        check_value("rst_mem_addr",     mem_ctrl_req_block_addr, 0);
        check_value("rst_spurious",     spurious_resp, 0);
        icache_req_valid = 1'b0;
        dcache_req_valid = 1'b0;
        rst_aH           = 1'b0;
        tick();

        // ---------------- 1: single icache read ----------------
        icache_req_valid      = 1'b1;
        icache_req_block_addr = 'h10;
        #1;
        check_value("t1_icache_ready", icache_req_ready, 1);
        check_value("t1_dcache_ready", dcache_req_ready, 0);
        tick();
        icache_req_valid = 1'b0;
        #1;
        check_value("t1_mem_valid", mem_ctrl_req_valid, 1);
        check_value("t1_mem_addr",  mem_ctrl_req_block_addr, 'h10);
        check_value("t1_mem_type",  mem_ctrl_req_type, READ);
        tick();
        check_value("t1_mem_valid_once", mem_ctrl_req_valid, 0);
        check_value("t1_no_early_resp",  icache_resp_valid, 0);
        tick();
        tick();
        mem_ctrl_resp_valid      = 1'b1;
        mem_ctrl_resp_block_data = c_DATA_AB;
        #1;
        check_value("t1_icache_resp",      icache_resp_valid, 1);
        check_value("t1_icache_resp_data", icache_resp_block_data, c_DATA_AB);
        check_value("t1_dcache_resp",      dcache_resp_valid, 0);
        tick();
        mem_ctrl_resp_valid = 1'b0;
        #1;
        check_value("t1_icache_resp_one", icache_resp_valid, 0);

        // ---------------- 2: simultaneous reads ----------------
        icache_req_valid      = 1'b1;
        icache_req_block_addr = 'h20;
        dcache_req_valid      = 1'b1;
        dcache_req_type       = READ;
        dcache_req_block_addr = 'h30;
        #1;
        check_value("t2_icache_ready", icache_req_ready, 1);
        check_value("t2_dcache_ready", dcache_req_ready, 0);
        tick();
        icache_req_valid = 1'b0;
        #1;
        check_value("t2_mem_addr_i",    mem_ctrl_req_block_addr, 'h20);
        check_value("t2_dready_issue",  dcache_req_ready, 0);
        tick();
        check_value("t2_dready_wait",   dcache_req_ready, 0);
        mem_ctrl_resp_valid      = 1'b1;
        mem_ctrl_resp_block_data = c_DATA_11;
        #1;
        check_value("t2_icache_resp",   icache_resp_valid, 1);
        check_value("t2_dcache_noresp", dcache_resp_valid, 0);
        tick();
        mem_ctrl_resp_valid = 1'b0;
        #1;
        check_value("t2_dcache_ready",  dcache_req_ready, 1);
        tick();
        dcache_req_valid = 1'b0;
        #1;
        check_value("t2_mem_addr_d",    mem_ctrl_req_block_addr, 'h30);
        check_value("t2_mem_valid_d",   mem_ctrl_req_valid, 1);
        tick();
        mem_ctrl_resp_valid      = 1'b1;
        mem_ctrl_resp_block_data = c_DATA_22;
        #1;
        check_value("t2_dcache_resp",      dcache_resp_valid, 1);
        check_value("t2_dcache_resp_data", dcache_resp_block_data, c_DATA_22);
        check_value("t2_icache_noresp",    icache_resp_valid, 0);
        tick();
        mem_ctrl_resp_valid = 1'b0;

        // ---------------- 3: starvation, limit 2 ----------------
        icache_req_valid      = 1'b1;
        icache_req_block_addr = 'h50;
        dcache_req_valid      = 1'b1;
        dcache_req_type       = READ;
        dcache_req_block_addr = 'h60;
        for (int g = 0; g < 6; g++) begin
            #1;
            check_value($sformatf("t3_grant%0d_icache", g), icache_req_ready,
                        c_starve_icache_wins[g]);
            check_value($sformatf("t3_grant%0d_dcache", g), dcache_req_ready,
                        !c_starve_icache_wins[g]);
            tick();                       // handshake -> ISSUE
            tick();                       // accepted  -> WAIT_RESP
            mem_ctrl_resp_valid = 1'b1;
            tick();                       // response  -> IDLE
            mem_ctrl_resp_valid = 1'b0;
        end
        icache_req_valid = 1'b0;
        dcache_req_valid = 1'b0;
        tick();

        // ---------------- 4: stalled dcache write ----------------
        mem_ctrl_req_ready    = 1'b0;
        dcache_req_valid      = 1'b1;
        dcache_req_type       = WRITE;
        dcache_req_block_addr = 'h40;
        dcache_req_width      = WORD;
        dcache_req_addr       = 'h100;
        dcache_req_block_data = c_DATA_D;
        #1;
        check_value("t4_dcache_ready", dcache_req_ready, 1);
        tick();
        dcache_req_valid      = 1'b0;
        dcache_req_block_data = '0;
        dcache_req_addr       = '0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) mem_ctrl_req_ready = 1'b1;
            #1;
            check_value($sformatf("t4_c%0d_valid", c), mem_ctrl_req_valid, 1);
            check_value($sformatf("t4_c%0d_type",  c), mem_ctrl_req_type, WRITE);
            check_value($sformatf("t4_c%0d_baddr", c), mem_ctrl_req_block_addr, 'h40);
            check_value($sformatf("t4_c%0d_width", c), mem_ctrl_req_width, WORD);
            check_value($sformatf("t4_c%0d_addr",  c), mem_ctrl_req_addr, 'h100);
            check_value($sformatf("t4_c%0d_data",  c), mem_ctrl_req_block_data, c_DATA_D);
            tick();
        end
        check_value("t4_valid_after",  mem_ctrl_req_valid, 0);
        check_value("t4_no_iresp",     icache_resp_valid, 0);
        check_value("t4_no_dresp",     dcache_resp_valid, 0);
        icache_req_valid = 1'b1;          // probe: a grant means IDLE
        #1;
        check_value("t4_idle_after", icache_req_ready, 1);
        icache_req_valid = 1'b0;
        tick();

        // ---------------- 5: spurious response ----------------
        check_value("t5_spurious_before", spurious_resp, 0);
        mem_ctrl_resp_valid      = 1'b1;
        mem_ctrl_resp_block_data = c_DATA_AB;
        #1;
        check_value("t5_no_iresp", icache_resp_valid, 0);
        check_value("t5_no_dresp", dcache_resp_valid, 0);
        tick();
        mem_ctrl_resp_valid = 1'b0;
        #1;
        check_value("t5_spurious_set", spurious_resp, 1);
        tick();
        tick();
        check_value("t5_spurious_hold", spurious_resp, 1);

        // ---------------- 6: reset during read ----------------
        icache_req_valid      = 1'b1;
        icache_req_block_addr = 'h70;
        tick();
        icache_req_valid = 1'b0;
        tick();                           // now in WAIT_RESP
        check_value("t6_in_wait", mem_ctrl_req_valid, 0);
        rst_aH              = 1'b1;
        dcache_req_valid    = 1'b1;
        dcache_req_type     = READ;
        mem_ctrl_resp_valid = 1'b1;
        #1;
        check_value("t6_rst_iresp",    icache_resp_valid, 0);
        check_value("t6_rst_dready",   dcache_req_ready, 0);
        check_value("t6_rst_ivalid",   mem_ctrl_req_valid, 0);
        check_value("t6_rst_spurious", spurious_resp, 0);
        mem_ctrl_resp_valid = 1'b0;
        dcache_req_valid    = 1'b0;
        tick();
        rst_aH = 1'b0;
        tick();
        mem_ctrl_resp_valid = 1'b1;       // late response for the lost read
        #1;
        check_value("t6_late_iresp", icache_resp_valid, 0);
        check_value("t6_late_dresp", dcache_resp_valid, 0);
        tick();
        mem_ctrl_resp_valid = 1'b0;
        #1;
        check_value("t6_late_spurious", spurious_resp, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
